streambuf_out_pp: RTL and testbench
===================================

Name: streambuf_out_pp

Overview:
- Double-buffered (ping-pong) output stream buffer for the decoder's output path.
- Accepts LANES words per write beat into one bank while the other bank drains one word per beat to the downstream consumer.
- Adds valid/ready handshakes on both sides, block framing (out_last) and a synchronous flush to the single-bank output buffer.
- Sits between the decoder core's parallel result port and the serial output interface.

Parameters:
- DATA_WIDTH, 4, bits per word.
- ADDR_WIDTH, 2, log2 of words per bank; DEPTH = 2**ADDR_WIDTH.
- LANES, 2, words written per input beat; must divide DEPTH; BEATS = DEPTH/LANES.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of buffer state.
- in_valid  in  1  input beat valid.
- in_ready  out  1  buffer can accept an input beat.
- in_data  in  LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  current output word.
- out_last  out  1  current word is the final word of its block.

Behaviour:
- State:
  - Two banks of DEPTH words.
  - Registered flags full[1:0].
  - wr_bank and rd_bank selects.
  - wr_ptr, a beat index of width ceil(log2(BEATS)), minimum 1 bit.
  - rd_ptr, ADDR_WIDTH bits.
- Reset (rst=0, async): full=0, wr_bank=rd_bank=0, pointers 0, storage cleared to 0. Resulting outputs: in_ready=1, out_valid=0, out_last=0, out_data=0.
- in_ready = !full[wr_bank]. It is registered-state only: no combinational path from out_ready.
- Write beat (in_valid && in_ready):
  - Lane k is written to bank[wr_bank][wr_ptr*LANES+k].
  - wr_ptr increments.
  - On the beat with wr_ptr==BEATS-1: set full[wr_bank], toggle wr_bank, wr_ptr=0.
- in_data is ignored while in_valid=0 or in_ready=0.
- out_valid = full[rd_bank]. out_data = bank[rd_bank][rd_ptr], read combinationally from storage.
- Latency: out_valid rises in the cycle after the edge that accepts the final beat of a block.
- out_last = out_valid && rd_ptr==DEPTH-1.
- Read beat (out_valid && out_ready):
  - rd_ptr increments.
  - On rd_ptr==DEPTH-1: clear full[rd_bank], toggle rd_bank, rd_ptr=0.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Simultaneous block-complete on write and block-drain on read always target different banks; both updates apply in the same edge.
- A freed bank becomes writable in the following cycle.
- Streaming with both sides always active is gapless on the output once the first block is full.
- Both banks full: in_ready=0 until one block fully drains.
- Flush (sync, priority over both handshakes):
  - Same register effect as reset, except storage is not cleared.
  - A partial block being written or drained is discarded.
- Async reset mid-operation: outputs go to reset values immediately and all partial blocks are discarded.

Optional Feature:
- Macro STREAMBUF_OUT_PP_BLKCNT_EN.
- Defined: adds output blk_cnt [15:0], which counts fully drained blocks (increments on each out_last read beat), wraps 65535->0, and is cleared by reset and flush.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Shared package streambuf_pkg holds:
  - A DEPTH/BEATS derivation function.
  - A clog2 helper.
  - Lane-slice width constants, shared with the single-bank buffer.
- Sub-module streambuf_bank: one DEPTH-word bank with a LANES-wide write port (we, beat addr) and a one-word read port. It is instantiated twice.

Test Plan (DATA_WIDTH=4, ADDR_WIDTH=2, LANES=2):
1. rst=0 pulse mid-cycle -> immediately in_ready=1, out_valid=0, out_last=0, out_data=0.
2. Beats in_data=8'h21 then 8'h43 with out_ready=1 -> out_valid rises the next cycle; out_data sequence is 1,2,3,4, with out_last=1 only on 4.
3. out_ready=0, offer 5 beats 8'h21,8'h43,8'h65,8'h87,8'hA9 -> first 4 accepted; in_ready=0 after the 4th; 5th stalls. out_data holds 1. On release, out_data is 1..8, then 9,10 after refill.
4. in_valid=1 and out_ready=1 continuously for 3 blocks -> out_valid stays 1 with no gaps after the first block. in_ready=0 for exactly 2 cycles per block in steady state. Word order is preserved.
5. Flush after 2 words of a block are read -> next cycle out_valid=0, in_ready=1. The next written block drains starting at its first word.
6. With STREAMBUF_OUT_PP_BLKCNT_EN, drain 3 blocks -> blk_cnt=3. Flush -> blk_cnt=0.

Source files
------------

// File: rtl/streambuf_pkg.sv
// Shared definitions for the stream output buffers: geometry helpers and lane-slice widths.
package streambuf_pkg;

  localparam int LANE_DATA_WIDTH = 32'sd4;
  localparam int LANE_COUNT      = 32'sd2;
  localparam int LANE_BUS_WIDTH  = LANE_DATA_WIDTH * LANE_COUNT;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 32'sd0;
    v = 32'sd1;
    while (v < n) begin
      v = v * 32'sd2;
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic int depth_of(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

  function automatic int beats_of(input int addr_width, input int lanes);
    return depth_of(addr_width) / lanes;
  endfunction

  // Pointer width for n states, never narrower than one bit
  function automatic int ptr_width(input int n);
    return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
  endfunction

endpackage

// File: rtl/streambuf_bank.sv
// One DEPTH-word storage bank: LANES-wide beat write port and a one-word combinational read port.
module streambuf_bank
  import streambuf_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_DATA_WIDTH,
  parameter int ADDR_WIDTH = 2,
  parameter int LANES      = LANE_COUNT,
  parameter int BEAT_W     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [BEAT_W-1:0]           beat_addr,
  input  logic [LANES*DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]       rdata
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] base_s;

  // First word address covered by the addressed beat
  always_comb begin
    base_s = ADDR_WIDTH'(beat_addr) * ADDR_WIDTH'(LANES);
  end

  // Storage write, cleared only by the hard reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 32'sd0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      for (int k = 32'sd0; k < LANES; k++) begin
        mem_r[base_s + ADDR_WIDTH'(k)] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/streambuf_out_pp.sv
// Ping-pong output stream buffer: one bank fills by LANES-word beats while the other drains word by word.
// Optional STREAMBUF_OUT_PP_BLKCNT_EN adds blk_cnt, a wrapping count of fully drained blocks.
module streambuf_out_pp
  import streambuf_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_DATA_WIDTH,
  parameter int ADDR_WIDTH = 2,
  parameter int LANES      = LANE_COUNT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last
`ifdef STREAMBUF_OUT_PP_BLKCNT_EN
  ,
  output logic [15:0]                 blk_cnt
`endif
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int BEATS = beats_of(ADDR_WIDTH, LANES);
  localparam int WP_W  = ptr_width(BEATS);

  logic [1:0]            full_r, full_nxt_s;
  logic                  wr_bank_r, wr_bank_nxt_s;
  logic                  rd_bank_r, rd_bank_nxt_s;
  logic [WP_W-1:0]       wr_ptr_r, wr_ptr_nxt_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic                  wr_fire_s, rd_fire_s, wr_done_s, rd_done_s;
  logic [1:0]            bank_we_s;
  logic [DATA_WIDTH-1:0] rdata_s [2];

  assign in_ready  = ~full_r[wr_bank_r];
  assign out_valid = full_r[rd_bank_r];
  assign out_data  = rdata_s[rd_bank_r];
  assign out_last  = out_valid & (rd_ptr_r == ADDR_WIDTH'(DEPTH - 1));

  assign wr_fire_s = in_valid & in_ready;
  assign rd_fire_s = out_valid & out_ready;
  assign wr_done_s = wr_fire_s & (wr_ptr_r == WP_W'(BEATS - 1));
  assign rd_done_s = rd_fire_s & (rd_ptr_r == ADDR_WIDTH'(DEPTH - 1));

  // A flushing cycle must not disturb stored words either
  assign bank_we_s[0] = wr_fire_s & ~flush & ~wr_bank_r;
  assign bank_we_s[1] = wr_fire_s & ~flush &  wr_bank_r;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    streambuf_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANES      (LANES),
      .BEAT_W     (WP_W)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .we        (bank_we_s[b]),
      .beat_addr (wr_ptr_r),
      .wdata     (in_data),
      .raddr     (rd_ptr_r),
      .rdata     (rdata_s[b])
    );
  end

  // Next-state for flags, bank selects and pointers; flush overrides both handshakes
  always_comb begin
    full_nxt_s    = full_r;
    wr_bank_nxt_s = wr_bank_r;
    rd_bank_nxt_s = rd_bank_r;
    wr_ptr_nxt_s  = wr_ptr_r;
    rd_ptr_nxt_s  = rd_ptr_r;
    if (flush) begin
      full_nxt_s    = 2'b00;
      wr_bank_nxt_s = 1'b0;
      rd_bank_nxt_s = 1'b0;
      wr_ptr_nxt_s  = '0;
      rd_ptr_nxt_s  = '0;
    end else begin
      if (wr_done_s) begin
        full_nxt_s[wr_bank_r] = 1'b1;
        wr_bank_nxt_s         = ~wr_bank_r;
        wr_ptr_nxt_s          = '0;
      end else if (wr_fire_s) begin
        wr_ptr_nxt_s = wr_ptr_r + WP_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      // Completing and draining banks always differ, so both flag updates may land together
      if (rd_done_s) begin
        full_nxt_s[rd_bank_r] = 1'b0;
        rd_bank_nxt_s         = ~rd_bank_r;
        rd_ptr_nxt_s          = '0;
      end else if (rd_fire_s) begin
        rd_ptr_nxt_s = rd_ptr_r + ADDR_WIDTH'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
    end else begin
      full_r    <= full_nxt_s;
      wr_bank_r <= wr_bank_nxt_s;
      rd_bank_r <= rd_bank_nxt_s;
      wr_ptr_r  <= wr_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
    end
  end

`ifdef STREAMBUF_OUT_PP_BLKCNT_EN
  logic [15:0] blk_cnt_r;

  // Drained-block counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt_r <= 16'd0;
    end else if (flush) begin
      blk_cnt_r <= 16'd0;
    end else if (rd_done_s) begin
      blk_cnt_r <= blk_cnt_r + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_r;
`endif

endmodule

// File: tb/tb_streambuf_out_pp.sv
// Self-checking bench for streambuf_out_pp: cycle vector table plus a free-running scoreboard.
module tb_streambuf_out_pp;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_last;
`ifdef STREAMBUF_OUT_PP_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  int checks = 0;
  int errors = 0;

  streambuf_out_pp dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef STREAMBUF_OUT_PP_BLKCNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: words of completed blocks as {last, data}, plus the block still being filled
  logic [4:0] exp_q[$];
  logic [3:0] part_q[$];
  int         drained_m = 0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      part_q.delete();
      drained_m = 0;
    end else begin
      chk("sb_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("sb_in_ready", {31'd0, in_ready}, {31'd0, ((exp_q.size() + DEPTH - 1) / DEPTH) < 2});
`ifdef STREAMBUF_OUT_PP_BLKCNT_EN
      chk("sb_blk_cnt", {16'd0, blk_cnt}, drained_m & 32'hFFFF);
`endif
      if (flush) begin
        exp_q.delete();
        part_q.delete();
        drained_m = 0;
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) begin
          logic [4:0] e;
          e = exp_q.pop_front();
          chk("sb_out_data", {28'd0, out_data}, {28'd0, e[3:0]});
          chk("sb_out_last", {31'd0, out_last}, {31'd0, e[4]});
          if (e[4]) drained_m++;
        end
        if (in_valid && in_ready) begin
          part_q.push_back(in_data[3:0]);
          part_q.push_back(in_data[7:4]);
          if (part_q.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) exp_q.push_back({i == DEPTH - 1, part_q[i]});
            part_q.delete();
          end
        end
      end
    end
  end

  typedef struct packed {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [3:0] od;
    logic       ol;
  } vec_t;

  vec_t vecs[26];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL %s: out_valid timeout", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (out_valid && n < 40) begin
      cyc();
      n++;
    end
    if (out_valid) begin
      errors++;
      $display("FAIL %s: drain timeout", name);
    end
  endtask

  initial begin
    int low;
    int gaps;
    logic acc;

    //          iv   d      ordy  ir    ov    od     ol
    vecs[0]  = {1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0};
    vecs[1]  = {1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 4'd1,  1'b0};
    vecs[2]  = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd1,  1'b0};
    vecs[3]  = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd2,  1'b0};
    vecs[4]  = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd3,  1'b0};
    vecs[5]  = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd4,  1'b1};
    vecs[6]  = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    vecs[7]  = {1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    vecs[8]  = {1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0};
    vecs[9]  = {1'b1, 8'h65, 1'b0, 1'b1, 1'b1, 4'd1,  1'b0};
    vecs[10] = {1'b1, 8'h87, 1'b0, 1'b1, 1'b1, 4'd1,  1'b0};
    vecs[11] = {1'b1, 8'hA9, 1'b0, 1'b0, 1'b1, 4'd1,  1'b0};
    vecs[12] = {1'b1, 8'hA9, 1'b0, 1'b0, 1'b1, 4'd1,  1'b0};
    vecs[13] = {1'b1, 8'hA9, 1'b1, 1'b0, 1'b1, 4'd1,  1'b0};
    vecs[14] = {1'b1, 8'hA9, 1'b1, 1'b0, 1'b1, 4'd2,  1'b0};
    vecs[15] = {1'b1, 8'hA9, 1'b1, 1'b0, 1'b1, 4'd3,  1'b0};
    vecs[16] = {1'b1, 8'hA9, 1'b1, 1'b0, 1'b1, 4'd4,  1'b1};
    vecs[17] = {1'b1, 8'hA9, 1'b1, 1'b1, 1'b1, 4'd5,  1'b0};
    vecs[18] = {1'b1, 8'hCB, 1'b1, 1'b1, 1'b1, 4'd6,  1'b0};
    vecs[19] = {1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd7,  1'b0};
    vecs[20] = {1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd8,  1'b1};
    vecs[21] = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd9,  1'b0};
    vecs[22] = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd10, 1'b0};
    vecs[23] = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd11, 1'b0};
    vecs[24] = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd12, 1'b1};
    vecs[25] = {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd5,  1'b0};

    // Reset state
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    cyc();

    // Single block drain, then backpressure with both banks full and refill
    for (int i = 0; i < 26; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].ir});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
      chk($sformatf("vec%0d_out_data", i), {28'd0, out_data}, {28'd0, vecs[i].od});
      chk($sformatf("vec%0d_out_last", i), {31'd0, out_last}, {31'd0, vecs[i].ol});
      cyc();
    end

    // Continuous streaming on both sides
    low = 0;
    gaps = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 8'h10;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 4 && c < 16) begin
        if (!in_ready) low++;
        if (!out_valid) gaps++;
      end
      acc = in_ready;
      cyc();
      if (acc) in_data = in_data + 8'h13;
    end
    in_valid = 1'b0;
    chk("stream_in_ready_low_cycles", low, 32'd6);
    chk("stream_out_gaps", gaps, 32'd0);
    wait_drain("stream");

    // Flush in the middle of a drain
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h21;
    cyc();
    in_data = 8'h43;
    cyc();
    in_valid = 1'b0;
    wait_valid("flush_fill");
    out_ready = 1'b1;
    cyc();
    cyc();
    out_ready = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data = 8'hED;
    cyc();
    in_data = 8'hFC;
    cyc();
    in_valid = 1'b0;
    wait_valid("flush_refill");
    chk("flush_first_word", {28'd0, out_data}, 32'hD);
    chk("flush_first_last", {31'd0, out_last}, 32'd0);
    out_ready = 1'b1;
    wait_drain("flush_refill");

    // Asynchronous reset in the middle of a block
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (3) cyc();
    in_valid = 1'b0;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_last", {31'd0, out_last}, 32'd0);
    chk("async_rst_out_data", {28'd0, out_data}, 32'd0);
    #3 rst = 1'b1;
    cyc();

    // Three full blocks through, then a flush
    out_ready = 1'b1;
    in_data = 8'h31;
    for (int b = 0; b < 6; b++) begin
      int n;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
        cyc();
        n++;
      end
      cyc();
      in_data = in_data + 8'h22;
    end
    in_valid = 1'b0;
    wait_drain("blk_drain");
    cyc();
`ifdef STREAMBUF_OUT_PP_BLKCNT_EN
    chk("blk_cnt_three", {16'd0, blk_cnt}, 32'd3);
`endif
    flush = 1'b1;
    cyc();
    flush = 1'b0;
`ifdef STREAMBUF_OUT_PP_BLKCNT_EN
    chk("blk_cnt_flush", {16'd0, blk_cnt}, 32'd0);
`endif
    chk("final_out_valid", {31'd0, out_valid}, 32'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
